// File: rtl/core_pkg.sv
// Shared types and constants for the PC/fetch sequencer.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;

endpackage

// File: rtl/status_flag_reg.sv
// N/Z/V status flag register with write enable.
// Latency: one cycle from write to q.
// Backpressure: none; the caller gates the write enable.
module status_flag_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] d,
    output logic [2:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 3'b000;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, fetch handshake FSM and status flags feeding the branch stage.
// Latency: instr_valid one cycle after imem_ready; PC/flags update on the commit edge.
// Backpressure: stall holds EXEC; imem_ready low keeps FETCH until the timeout fires.
module pc_fetch_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] out_pc,
    input  logic        enable,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        flag_we,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        n,
    output logic        z,
    output logic        v,
    output logic        halted,
    output logic [1:0]  err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [XLEN-1:0]  pc_nxt;
    logic [XLEN-1:0]  instr_nxt;
    logic [1:0]       err_nxt;
    logic [7:0]       tmo_cnt, tmo_cnt_nxt;
    logic             flag_wr;
    logic [2:0]       flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            instr   <= '0;
            err     <= ERR_NONE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            instr   <= instr_nxt;
            err     <= err_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        instr_nxt   = instr;
        err_nxt     = err;
        tmo_cnt_nxt = tmo_cnt;
        flag_wr     = 1'b0;

        unique case (state)
            BOOT: state_nxt = FETCH;

            FETCH: begin
                if (imem_ready) begin
                    instr_nxt   = imem_rdata;
                    tmo_cnt_nxt = '0;
                    state_nxt   = EXEC;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_nxt   = ERR_TIMEOUT;
                    state_nxt = HALT;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end

            EXEC: begin
                if (!stall) begin
                    flag_wr = flag_we;
                    if (halt_req) begin
                        state_nxt = HALT;
                    end else if (enable) begin
                        // A misaligned redirect is fatal: keep the faulting slot's PC.
                        if (out_pc[1:0] != 2'b00) begin
                            err_nxt   = ERR_MISALIGN;
                            state_nxt = HALT;
                        end else begin
                            pc_nxt    = out_pc;
                            state_nxt = FETCH;
                        end
                    end else begin
                        pc_nxt    = pc4;
                        state_nxt = FETCH;
                    end
                end
            end

            HALT: state_nxt = HALT;

            default: state_nxt = HALT;
        endcase
    end

    status_flag_reg u_flags (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (flag_wr),
        .d     ({alu_n, alu_z, alu_v}),
        .q     (flags_q)
    );

    assign {n, z, v}   = flags_q;
    assign pc4         = pc + 32'd4;
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with RESET_PC = 0x100 and TIMEOUT = 4.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] out_pc;
    logic        enable;
    logic        stall;
    logic        halt_req;
    logic        alu_n, alu_z, alu_v;
    logic        flag_we;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc, pc4, instr;
    logic        instr_valid;
    logic        n, z, v;
    logic        halted;
    logic [1:0]  err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    // Instruction memory returns a word derived from the address.
    assign imem_rdata = imem_addr ^ KEY;

    pc_fetch_ctrl #(
        .RESET_PC (32'h0000_0100),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .out_pc      (out_pc),
        .enable      (enable),
        .stall       (stall),
        .halt_req    (halt_req),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_v       (alu_v),
        .flag_we     (flag_we),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .pc          (pc),
        .pc4         (pc4),
        .instr       (instr),
        .instr_valid (instr_valid),
        .n           (n),
        .z           (z),
        .v           (v),
        .halted      (halted),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " pc"},          pc,                 32'h0000_0100);
        check({tag, " instr"},       instr,              32'h0);
        check({tag, " nzv"},         {29'd0, n, z, v},   32'h0);
        check({tag, " err"},         {30'd0, err},       32'h0);
        check({tag, " imem_req"},    {31'd0, imem_req},  32'h0);
        check({tag, " instr_valid"}, {31'd0, instr_valid}, 32'h0);
        check({tag, " halted"},      {31'd0, halted},    32'h0);
    endtask

    initial begin
        rst_n = 1'b0; out_pc = '0; enable = 0; stall = 0; halt_req = 0;
        alu_n = 0; alu_z = 0; alu_v = 0; flag_we = 0; imem_ready = 1'b1;

        step();
        check_reset_values("rst");

        // Boot and sequential fetch/commit
        rst_n = 1'b1;
        step();
        check("boot req",  {31'd0, imem_req}, 32'h1);
        check("boot addr", imem_addr, 32'h0000_0100);
        check("boot iv",   {31'd0, instr_valid}, 32'h0);
        step();
        check("exec0 iv",    {31'd0, instr_valid}, 32'h1);
        check("exec0 instr", instr, 32'h0000_0100 ^ KEY);
        check("exec0 pc4",   pc4, 32'h0000_0104);
        check("exec0 req",   {31'd0, imem_req}, 32'h0);
        step();
        check("seq1 addr", imem_addr, 32'h0000_0104);
        step();
        check("seq1 instr", instr, 32'h0000_0104 ^ KEY);
        step();
        check("seq2 pc", pc, 32'h0000_0108);
        step();
        check("seq2 iv", {31'd0, instr_valid}, 32'h1);

        // Stall for three EXEC cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall pc",    pc, 32'h0000_0108);
            check("stall instr", instr, 32'h0000_0108 ^ KEY);
            check("stall iv",    {31'd0, instr_valid}, 32'h1);
        end
        stall = 1'b0; flag_we = 1'b1; alu_z = 1'b1;
        step();
        check("unstall pc", pc, 32'h0000_010C);
        check("flag z set", {31'd0, z}, 32'h1);
        flag_we = 1'b0; alu_z = 1'b0;
        step();

        // Redirect with flag_we low must leave n alone
        enable = 1'b1; out_pc = 32'h0000_0040; alu_n = 1'b1;
        step();
        check("redir addr", imem_addr, 32'h0000_0040);
        check("n held",     {31'd0, n}, 32'h0);
        check("z held",     {31'd0, z}, 32'h1);
        enable = 1'b0; alu_n = 1'b0;
        step();
        check("redir instr", instr, 32'h0000_0040 ^ KEY);

        // Misaligned redirect
        enable = 1'b1; out_pc = 32'h0000_0042;
        step();
        check("mis err",    {30'd0, err}, 32'h2);
        check("mis halted", {31'd0, halted}, 32'h1);
        check("mis pc",     pc, 32'h0000_0040);
        check("mis iv",     {31'd0, instr_valid}, 32'h0);
        enable = 1'b0;
        step();
        check("halt sticky", {31'd0, halted}, 32'h1);
        check("halt req",    {31'd0, imem_req}, 32'h0);

        // Asynchronous reset, then fetch timeout with imem_ready low
        #2 rst_n = 1'b0;
        #1 check_reset_values("arst");
        imem_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("tmo req", {31'd0, imem_req}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("tmo waiting", {31'd0, halted}, 32'h0);
        end
        step();
        check("tmo halted", {31'd0, halted}, 32'h1);
        check("tmo err",    {30'd0, err}, 32'h1);
        imem_ready = 1'b1;
        step();
        check("tmo ignore ready", {31'd0, halted}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("tmo rst");

        // PC wrap, then halt_req commit
        step();
        rst_n = 1'b1;
        step();
        step();
        enable = 1'b1; out_pc = 32'hFFFF_FFFC;
        step();
        check("wrap addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap pc4",  pc4, 32'h0000_0000);
        enable = 1'b0;
        step();
        step();
        check("wrap pc", pc, 32'h0000_0000);
        step();
        halt_req = 1'b1; flag_we = 1'b1; alu_v = 1'b1;
        step();
        check("hreq halted", {31'd0, halted}, 32'h1);
        check("hreq err",    {30'd0, err}, 32'h0);
        check("hreq pc",     pc, 32'h0000_0000);
        check("hreq v",      {31'd0, v}, 32'h1);
        halt_req = 1'b0; flag_we = 1'b0; alu_v = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
